// File: rtl/tx_packet_arbiter_if.sv
// Master/serializer side bundle of tx_packet_arbiter.
// slave = arbiter view, master = view of the masters plus serializer driving it.
interface tx_packet_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req_bus;
    logic [8*N_REQ-1:0] m_tx_data_bus;
    logic [N_REQ-1:0]   m_tx_valid_bus;
    logic [N_REQ-1:0]   m_tx_ready_bus;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [N_REQ-1:0]   grant_bus;
    logic               busy;
    logic               timeout_flag;

    modport slave (
        input  req_bus, m_tx_data_bus, m_tx_valid_bus, tx_ready,
        output m_tx_ready_bus, tx_data, tx_valid, grant_bus, busy, timeout_flag
    );

    modport master (
        output req_bus, m_tx_data_bus, m_tx_valid_bus, tx_ready,
        input  m_tx_ready_bus, tx_data, tx_valid, grant_bus, busy, timeout_flag
    );
endinterface

// File: rtl/tx_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one byte-serial TX among N_REQ masters.
// Optional forced release of a stalled grant: define PKT_TIMEOUT_EN.
module tx_packet_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  n_rst,
    tx_packet_arbiter_if.slave    io_arb
);
    localparam int unsigned IDXW = $clog2(N_REQ);

    if (N_REQ < 2 || TIMEOUT < 1 || TIMEOUT > 65536) begin : g_cfg_check
        $error("tx_packet_arbiter: N_REQ must be >= 2 and TIMEOUT in 1..65536");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_HOLDOFF
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [N_REQ-1:0] r_grant;
    logic [IDXW-1:0]  r_gidx;
    logic [IDXW-1:0]  r_ptr;
    logic [8:0]       r_byte_cnt;
    logic [7:0]       r_pkt_len;

    logic [IDXW-1:0]  w_pick_hi;
    logic [IDXW-1:0]  w_pick_lo;
    logic [IDXW-1:0]  w_pick;
    logic [N_REQ-1:0] w_pick_oh;
    logic             w_hit_hi;
    logic [7:0]       w_gdata;
    logic             w_strobe;
    logic             w_crc;
    logic             w_timeout;

    // Round-robin pick: lowest requester at/after r_ptr, else lowest overall (wrap).
    always_comb begin
        w_pick_hi = '0;
        w_pick_lo = '0;
        w_hit_hi  = 1'b0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (io_arb.req_bus[i-1]) begin
                w_pick_lo = IDXW'(i-1);
                if ((i-1) >= 32'(r_ptr)) begin
                    w_pick_hi = IDXW'(i-1);
                    w_hit_hi  = 1'b1;
                end
            end
        end
        w_pick            = w_hit_hi ? w_pick_hi : w_pick_lo;
        w_pick_oh         = '0;
        w_pick_oh[w_pick] = 1'b1;
    end

    always_comb begin
        w_gdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_gdata = w_gdata | io_arb.m_tx_data_bus[8*i +: 8];
            end
        end
    end

    assign w_strobe = |(io_arb.m_tx_valid_bus & r_grant);
    assign w_crc    = (r_state == S_GRANT) && w_strobe &&
                      (r_byte_cnt == (9'd4 + {1'b0, r_pkt_len}));

`ifdef PKT_TIMEOUT_EN
    logic [15:0] r_idle_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_idle_cnt <= '0;
        end else if (r_state != S_GRANT || w_strobe) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == S_GRANT) && !w_strobe &&
                       (r_idle_cnt == 16'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (|io_arb.req_bus && io_arb.tx_ready) w_next = S_GRANT;
            S_GRANT:   if (w_crc || w_timeout)                 w_next = S_HOLDOFF;
            S_HOLDOFF: if (io_arb.tx_ready)                    w_next = S_IDLE;
            default:                                           w_next = S_IDLE;
        endcase
    end

    // LEN is captured on the strobe at count 3; LEN 0 still carries one data byte.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_byte_cnt <= '0;
            r_pkt_len  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_GRANT) begin
                        r_grant    <= w_pick_oh;
                        r_gidx     <= w_pick;
                        r_byte_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_strobe) begin
                        if (r_byte_cnt != '1) begin
                            r_byte_cnt <= r_byte_cnt + 9'd1;
                        end
                        if (r_byte_cnt == 9'd3) begin
                            r_pkt_len <= (w_gdata == 8'd0) ? 8'd1 : w_gdata;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (io_arb.tx_ready) begin
                        r_grant <= '0;
                        r_ptr   <= (r_gidx == IDXW'(N_REQ - 1)) ? '0 : r_gidx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Forwarding stays combinational: masters pace on tx_ready & !tx_valid.
    always_comb begin
        io_arb.tx_data        = '0;
        io_arb.tx_valid       = 1'b0;
        io_arb.m_tx_ready_bus = '0;
        if (r_state == S_GRANT) begin
            io_arb.tx_data        = w_gdata;
            io_arb.tx_valid       = w_strobe;
            io_arb.m_tx_ready_bus = r_grant & {N_REQ{io_arb.tx_ready}};
        end
        io_arb.grant_bus    = r_grant;
        io_arb.busy         = (r_state != S_IDLE);
        io_arb.timeout_flag = w_timeout;
    end
endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Directed self-checking bench for tx_packet_arbiter (N_REQ=2, TIMEOUT=16).
// Covers reset, single packet, alternation, foreign strobes, LEN bounds, mid-packet reset, stall.
module tb_tx_packet_arbiter;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    tx_packet_arbiter_if #(.N_REQ(2)) u_if ();

    tx_packet_arbiter #(.N_REQ(2), .TIMEOUT(16)) u_dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .io_arb (u_if)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0] frame [0:259];
    int         flen;
    logic [7:0] od;
    logic       ov;
    logic [1:0] og;
    logic [1:0] ordy;

    task automatic build_frame(input int src, input int len);
        int         n;
        logic [7:0] crc;
        n        = (len == 0) ? 1 : len;
        frame[0] = 8'hA5;
        frame[1] = 8'(8'h10 + src);
        frame[2] = 8'(src);
        frame[3] = 8'(len);
        for (int i = 0; i < n; i++) frame[4+i] = 8'(len*7 + i*3 + src + 1);
        crc = '0;
        for (int i = 0; i < 4 + n; i++) crc = crc ^ frame[i];
        frame[4+n] = crc;
        flen       = 5 + n;
    endtask

    // One-cycle strobe from master m; observed outputs are captured mid-strobe.
    task automatic strobe(input int m, input logic [7:0] b, output logic [7:0] d,
                          output logic v, output logic [1:0] g, output logic [1:0] r);
        @(negedge clk);
        u_if.m_tx_data_bus[8*m +: 8] = b;
        u_if.m_tx_valid_bus[m]       = 1'b1;
        #1;
        d = u_if.tx_data;
        v = u_if.tx_valid;
        g = u_if.grant_bus;
        r = u_if.m_tx_ready_bus;
        @(posedge clk);
        #1;
        u_if.m_tx_valid_bus = '0;
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (u_if.m_tx_ready_bus != '0) break;
        end
    endtask

    task automatic test_reset();
        n_rst               = 1'b0;
        u_if.req_bus        = '0;
        u_if.m_tx_data_bus  = '0;
        u_if.m_tx_valid_bus = '0;
        u_if.tx_ready       = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (u_if.grant_bus !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", u_if.grant_bus); end
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", u_if.busy); end
        checks++; if (u_if.m_tx_ready_bus !== 2'b00) begin failures++; $display("FAIL reset_mready: got %b expected 00", u_if.m_tx_ready_bus); end
        checks++; if (u_if.tx_valid !== 1'b0 || u_if.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx: got valid=%b data=%h expected 0/00", u_if.tx_valid, u_if.tx_data); end
        checks++; if (u_if.timeout_flag !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", u_if.timeout_flag); end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL idle_no_req: got busy=%b expected 0", u_if.busy); end
    endtask

    task automatic test_single();
        u_if.tx_ready = 1'b0;
        @(negedge clk);
        u_if.req_bus = 2'b01;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (u_if.grant_bus !== 2'b00) begin failures++; $display("FAIL grant_needs_ready: got %b expected 00", u_if.grant_bus); end
        u_if.tx_ready = 1'b1;
        #1;
        checks++; if (u_if.m_tx_ready_bus !== 2'b00) begin failures++; $display("FAIL ready_latency: got %b expected 00", u_if.m_tx_ready_bus); end
        @(negedge clk);
        #1;
        checks++; if (u_if.grant_bus !== 2'b01 || u_if.m_tx_ready_bus !== 2'b01 || u_if.busy !== 1'b1) begin
            failures++; $display("FAIL single_grant: got grant=%b ready=%b busy=%b expected 01/01/1", u_if.grant_bus, u_if.m_tx_ready_bus, u_if.busy);
        end
        build_frame(0, 3);
        for (int k = 0; k < flen; k++) begin
            checks++; if (u_if.m_tx_ready_bus !== 2'b01) begin failures++; $display("FAIL single_early_end byte %0d: got ready=%b expected 01", k, u_if.m_tx_ready_bus); end
            if (k == 2) u_if.req_bus = 2'b00;
            strobe(0, frame[k], od, ov, og, ordy);
            checks++; if (od !== frame[k] || ov !== 1'b1 || og !== 2'b01) begin
                failures++; $display("FAIL single_byte %0d: got data=%h valid=%b grant=%b expected %h/1/01", k, od, ov, og, frame[k]);
            end
        end
        checks++; if (u_if.m_tx_ready_bus !== 2'b00 || u_if.tx_valid !== 1'b0 || u_if.busy !== 1'b1 || u_if.grant_bus !== 2'b01) begin
            failures++; $display("FAIL single_holdoff: got ready=%b valid=%b busy=%b grant=%b expected 00/0/1/01", u_if.m_tx_ready_bus, u_if.tx_valid, u_if.busy, u_if.grant_bus);
        end
        @(posedge clk);
        #1;
        checks++; if (u_if.grant_bus !== 2'b00 || u_if.busy !== 1'b0) begin
            failures++; $display("FAIL single_release: got grant=%b busy=%b expected 00/0", u_if.grant_bus, u_if.busy);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g;
        int         m;
        exp_g        = 2'b10;
        u_if.req_bus = 2'b11;
        for (int p = 0; p < 4; p++) begin
            wait_ready();
            checks++; if (u_if.grant_bus !== exp_g || u_if.m_tx_ready_bus !== exp_g) begin
                failures++; $display("FAIL alt_grant pkt %0d: got grant=%b ready=%b expected %b", p, u_if.grant_bus, u_if.m_tx_ready_bus, exp_g);
            end
            m = exp_g[1] ? 1 : 0;
            build_frame(m, 1);
            for (int k = 0; k < flen; k++) begin
                strobe(m, frame[k], od, ov, og, ordy);
                checks++; if (od !== frame[k] || ov !== 1'b1 || og !== exp_g) begin
                    failures++; $display("FAIL alt_byte pkt %0d byte %0d: got data=%h valid=%b grant=%b expected %h/1/%b", p, k, od, ov, og, frame[k], exp_g);
                end
            end
            checks++; if (u_if.m_tx_ready_bus !== 2'b00 || u_if.busy !== 1'b1) begin
                failures++; $display("FAIL alt_holdoff pkt %0d: got ready=%b busy=%b expected 00/1", p, u_if.m_tx_ready_bus, u_if.busy);
            end
            exp_g = ~exp_g;
        end
        u_if.req_bus = 2'b00;
        @(posedge clk);
        #1;
        checks++; if (u_if.grant_bus !== 2'b00) begin failures++; $display("FAIL alt_release: got %b expected 00", u_if.grant_bus); end
    endtask

    task automatic test_nongranted();
        u_if.req_bus = 2'b01;
        wait_ready();
        checks++; if (u_if.grant_bus !== 2'b01) begin failures++; $display("FAIL ng_grant: got %b expected 01", u_if.grant_bus); end
        build_frame(0, 2);
        for (int k = 0; k < flen; k++) begin
            if (k == 3) begin
                strobe(1, 8'h77, od, ov, og, ordy);
                checks++; if (ov !== 1'b0 || ordy !== 2'b01) begin
                    failures++; $display("FAIL ng_foreign_strobe: got valid=%b ready=%b expected 0/01", ov, ordy);
                end
            end
            if (k == flen - 1) u_if.req_bus = 2'b00;
            checks++; if (u_if.m_tx_ready_bus !== 2'b01) begin failures++; $display("FAIL ng_early_end byte %0d: got ready=%b expected 01", k, u_if.m_tx_ready_bus); end
            strobe(0, frame[k], od, ov, og, ordy);
            checks++; if (od !== frame[k] || ov !== 1'b1) begin
                failures++; $display("FAIL ng_byte %0d: got data=%h valid=%b expected %h/1", k, od, ov, frame[k]);
            end
        end
        checks++; if (u_if.m_tx_ready_bus !== 2'b00 || u_if.busy !== 1'b1) begin
            failures++; $display("FAIL ng_holdoff: got ready=%b busy=%b expected 00/1", u_if.m_tx_ready_bus, u_if.busy);
        end
    endtask

    task automatic test_len_bounds();
        int lens [2];
        lens[0]      = 0;
        lens[1]      = 255;
        u_if.req_bus = 2'b01;
        for (int t = 0; t < 2; t++) begin
            wait_ready();
            checks++; if (u_if.m_tx_ready_bus !== 2'b01) begin failures++; $display("FAIL len_grant len %0d: got ready=%b expected 01", lens[t], u_if.m_tx_ready_bus); end
            build_frame(0, lens[t]);
            for (int k = 0; k < flen; k++) begin
                checks++; if (u_if.m_tx_ready_bus !== 2'b01) begin failures++; $display("FAIL len_early_end len %0d byte %0d: got ready=%b expected 01", lens[t], k, u_if.m_tx_ready_bus); end
                strobe(0, frame[k], od, ov, og, ordy);
                checks++; if (od !== frame[k] || ov !== 1'b1) begin
                    failures++; $display("FAIL len_byte len %0d byte %0d: got data=%h valid=%b expected %h/1", lens[t], k, od, ov, frame[k]);
                end
            end
            checks++; if (u_if.m_tx_ready_bus !== 2'b00 || u_if.busy !== 1'b1) begin
                failures++; $display("FAIL len_holdoff len %0d: got ready=%b busy=%b expected 00/1", lens[t], u_if.m_tx_ready_bus, u_if.busy);
            end
            if (t == 0) begin
                u_if.tx_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    checks++; if (u_if.busy !== 1'b1 || u_if.grant_bus !== 2'b01 || u_if.m_tx_ready_bus !== 2'b00) begin
                        failures++; $display("FAIL holdoff_wait: got busy=%b grant=%b ready=%b expected 1/01/00", u_if.busy, u_if.grant_bus, u_if.m_tx_ready_bus);
                    end
                end
                u_if.tx_ready = 1'b1;
            end
        end
        u_if.req_bus = 2'b00;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        u_if.req_bus = 2'b01;
        wait_ready();
        checks++; if (u_if.grant_bus !== 2'b01) begin failures++; $display("FAIL rst_mid_grant: got %b expected 01", u_if.grant_bus); end
        build_frame(0, 4);
        for (int k = 0; k < 5; k++) strobe(0, frame[k], od, ov, og, ordy);
        @(negedge clk);
        n_rst                  = 1'b0;
        u_if.m_tx_valid_bus[0] = 1'b1;
        #1;
        checks++; if (u_if.grant_bus !== 2'b00 || u_if.tx_valid !== 1'b0 || u_if.m_tx_ready_bus !== 2'b00 || u_if.busy !== 1'b0) begin
            failures++; $display("FAIL rst_mid_outputs: got grant=%b valid=%b ready=%b busy=%b expected 00/0/00/0", u_if.grant_bus, u_if.tx_valid, u_if.m_tx_ready_bus, u_if.busy);
        end
        u_if.m_tx_valid_bus = '0;
        @(negedge clk);
        n_rst        = 1'b1;
        u_if.req_bus = 2'b11;
        wait_ready();
        checks++; if (u_if.grant_bus !== 2'b01) begin failures++; $display("FAIL rst_ptr_restart: got %b expected 01", u_if.grant_bus); end
        u_if.req_bus = 2'b01;
        build_frame(0, 1);
        for (int k = 0; k < flen; k++) strobe(0, frame[k], od, ov, og, ordy);
        u_if.req_bus = 2'b00;
        checks++; if (u_if.m_tx_ready_bus !== 2'b00 || u_if.busy !== 1'b1) begin
            failures++; $display("FAIL rst_post_holdoff: got ready=%b busy=%b expected 00/1", u_if.m_tx_ready_bus, u_if.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        u_if.req_bus = 2'b01;
        wait_ready();
        checks++; if (u_if.grant_bus !== 2'b01) begin failures++; $display("FAIL stall_grant: got %b expected 01", u_if.grant_bus); end
        build_frame(0, 1);
        for (int k = 0; k < 2; k++) strobe(0, frame[k], od, ov, og, ordy);
`ifdef PKT_TIMEOUT_EN
        u_if.req_bus = 2'b11;
        for (int c = 1; c <= 16; c++) begin
            checks++; if (u_if.timeout_flag !== (c == 16)) begin
                failures++; $display("FAIL timeout_pulse cycle %0d: got %b expected %b", c, u_if.timeout_flag, (c == 16));
            end
            @(posedge clk);
            #1;
        end
        checks++; if (u_if.busy !== 1'b1 || u_if.m_tx_ready_bus !== 2'b00 || u_if.timeout_flag !== 1'b0) begin
            failures++; $display("FAIL timeout_holdoff: got busy=%b ready=%b flag=%b expected 1/00/0", u_if.busy, u_if.m_tx_ready_bus, u_if.timeout_flag);
        end
        wait_ready();
        checks++; if (u_if.grant_bus !== 2'b10) begin failures++; $display("FAIL timeout_next_grant: got %b expected 10", u_if.grant_bus); end
        u_if.req_bus = 2'b00;
        build_frame(1, 0);
        for (int k = 0; k < flen; k++) strobe(1, frame[k], od, ov, og, ordy);
`else
        begin
            logic flag_seen;
            flag_seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                #1;
                flag_seen = flag_seen | u_if.timeout_flag;
            end
            checks++; if (flag_seen !== 1'b0) begin failures++; $display("FAIL stall_no_timeout: got flag=%b expected 0", flag_seen); end
            checks++; if (u_if.grant_bus !== 2'b01 || u_if.m_tx_ready_bus !== 2'b01) begin
                failures++; $display("FAIL stall_grant_held: got grant=%b ready=%b expected 01/01", u_if.grant_bus, u_if.m_tx_ready_bus);
            end
        end
        u_if.req_bus = 2'b00;
        for (int k = 2; k < flen; k++) strobe(0, frame[k], od, ov, og, ordy);
`endif
        checks++; if (u_if.m_tx_ready_bus !== 2'b00 || u_if.busy !== 1'b1) begin
            failures++; $display("FAIL stall_holdoff: got ready=%b busy=%b expected 00/1", u_if.m_tx_ready_bus, u_if.busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_nongranted();
        test_len_bounds();
        test_reset_mid();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
